seg7_capture_encode: RTL and testbench

//  Inverse of the hex-to-7-segment decode path. Samples an active-low gfedcba

---
 rtl/seg7_capture_encode.sv | 100 ++++++++++
 tb/tb_seg7_capture_encode.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_encode.sv
// Captures an active-low gfedcba segment bus, debounces it, and encodes each
// newly stable pattern back to a hex digit delivered over valid/ready.
module seg7_capture_encode #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       hex_ready,
  output logic [3:0] hex_out,
  output logic       hex_err,
  output logic       hex_valid,
  output logic       overrun
);

  typedef enum logic {S_WAIT, S_HOLD} state_t;

  localparam logic [6:0]       BLANK   = 7'h7F;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // Returns {err, hex}; unknown patterns encode as 0 with err set.
  function automatic logic [4:0] encode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [6:0]       seg_s, last_acc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stable, candidate, fresh, ovr_set, load;

  always_comb begin
    if (seg_in != seg_s)     cnt_nxt = CNT_W'(1);
    else if (cnt == CNT_MAX) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + CNT_W'(1);
  end

  assign stable    = (cnt == CNT_MAX);
  assign candidate = stable && (seg_s != last_acc) && (seg_s != BLANK);
  // Pattern becomes stable at this edge (a fresh arrival, not a continuing one).
  assign fresh     = (cnt_nxt == CNT_MAX) && ((cnt != CNT_MAX) || (seg_in != seg_s));
  assign ovr_set   = (state == S_HOLD) && fresh && (seg_in != last_acc) && (seg_in != BLANK);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_WAIT: if (candidate) begin
        load      = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: if (hex_ready) state_nxt = S_WAIT;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s     <= BLANK;
      cnt       <= '0;
      last_acc  <= BLANK;
      state     <= S_WAIT;
      hex_out   <= 4'h0;
      hex_err   <= 1'b0;
      hex_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      seg_s     <= seg_in;
      cnt       <= cnt_nxt;
      state     <= state_nxt;
      hex_valid <= (state_nxt == S_HOLD);
      if (load) begin
        {hex_err, hex_out} <= encode(seg_s);
        last_acc           <= seg_s;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_capture_encode.sv
// Scoreboard bench for seg7_capture_encode: expected digits are queued as
// patterns are driven and popped on each valid/ready transfer.
module tb_seg7_capture_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       hex_ready;
  logic [3:0] hex_out;
  logic       hex_err;
  logic       hex_valid;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  seg7_capture_encode #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .hex_ready(hex_ready),
    .hex_out(hex_out), .hex_err(hex_err), .hex_valid(hex_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Transfer happens at the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && hex_valid === 1'b1 && hex_ready === 1'b1) begin
      logic [4:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output got hex=%h err=%b with empty scoreboard", hex_out, hex_err);
      end else begin
        e = exp_q.pop_front();
        if ({hex_err, hex_out} !== e) begin
          fails++;
          $display("FAIL scoreboard got hex=%h err=%b expected hex=%h err=%b",
                   hex_out, hex_err, e[3:0], e[4]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d pending results expected 0", name, exp_q.size());
      exp_q.delete();
    end
    step(8);
  endtask

  task automatic test_reset;
    rst = 1'b1; seg_in = 7'h7F; hex_ready = 1'b0;
    step(2);
    rst = 1'b0;
    tests++; if (hex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b expected 0", hex_valid); end
    tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL reset_overrun got %b expected 0", overrun); end
    tests++; if (hex_out !== 4'h0)   begin fails++; $display("FAIL reset_hex got %h expected 0", hex_out); end
    tests++; if (hex_err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b expected 0", hex_err); end
  endtask

  task automatic test_latency;
    hex_ready = 1'b1;
    seg_in = 7'h40; exp_q.push_back(5'h00);
    step(4);
    tests++; if (hex_valid !== 1'b0) begin fails++; $display("FAIL latency_early got valid=%b expected 0", hex_valid); end
    step(1);
    tests++; if (hex_valid !== 1'b1) begin fails++; $display("FAIL latency_on_time got valid=%b expected 1", hex_valid); end
    step(1);
    tests++; if (hex_valid !== 1'b0) begin fails++; $display("FAIL single_pulse got valid=%b expected 0", hex_valid); end
    seg_in = 7'h7F;
    drain("latency");
  endtask

  task automatic test_glitch;
    hex_ready = 1'b1;
    seg_in = 7'h24;
    step(2);
    seg_in = 7'h30; exp_q.push_back(5'h03);
    step(8);
    seg_in = 7'h7F;
    drain("glitch");
  endtask

  task automatic test_error;
    hex_ready = 1'b1;
    seg_in = 7'h55; exp_q.push_back(5'h10);
    step(8);
    seg_in = 7'h7F;
    drain("error");
  endtask

  task automatic test_overrun;
    hex_ready = 1'b0;
    seg_in = 7'h79; exp_q.push_back(5'h01);
    step(6);
    tests++; if (hex_valid !== 1'b1 || hex_out !== 4'h1) begin
      fails++; $display("FAIL overrun_held got valid=%b hex=%h expected 1/1", hex_valid, hex_out);
    end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_premature got %b expected 0", overrun); end
    seg_in = 7'h12; exp_q.push_back(5'h05);
    step(6);
    tests++; if (hex_valid !== 1'b1 || hex_out !== 4'h1) begin
      fails++; $display("FAIL overrun_frozen got valid=%b hex=%h expected 1/1", hex_valid, hex_out);
    end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got %b expected 1", overrun); end
    hex_ready = 1'b1;
    drain("overrun");
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b expected 1", overrun); end
    seg_in = 7'h7F;
    step(4);
  endtask

  task automatic test_blank_repeat;
    hex_ready = 1'b1;
    seg_in = 7'h00; exp_q.push_back(5'h08);
    step(6);
    seg_in = 7'h7F; step(6);
    seg_in = 7'h00; step(6);
    seg_in = 7'h7F; step(10);
    drain("blank_repeat");
  endtask

  task automatic test_reset_hold;
    hex_ready = 1'b0;
    seg_in = 7'h06; exp_q.push_back(5'h0E);
    step(6);
    tests++; if (hex_valid !== 1'b1 || hex_out !== 4'hE) begin
      fails++; $display("FAIL hold_before_rst got valid=%b hex=%h expected 1/e", hex_valid, hex_out);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    void'(exp_q.pop_back());
    tests++; if (hex_valid !== 1'b0) begin fails++; $display("FAIL rst_hold_valid got %b expected 0", hex_valid); end
    tests++; if (overrun !== 1'b0)   begin fails++; $display("FAIL rst_hold_overrun got %b expected 0", overrun); end
    exp_q.push_back(5'h0E);
    step(4);
    tests++; if (hex_valid !== 1'b0) begin fails++; $display("FAIL rereport_early got %b expected 0", hex_valid); end
    step(1);
    tests++; if (hex_valid !== 1'b1 || hex_out !== 4'hE) begin
      fails++; $display("FAIL rereport got valid=%b hex=%h expected 1/e", hex_valid, hex_out);
    end
    hex_ready = 1'b1;
    drain("reset_hold");
  endtask

  task automatic test_back_to_back;
    logic [6:0] codes[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    hex_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      seg_in = codes[i];
      exp_q.push_back({1'b0, 4'(i)});
      step(6);
    end
    seg_in = 7'h7F;
    drain("back_to_back");
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b expected 0", overrun); end
  endtask

  initial begin
    rst = 1'b1; seg_in = 7'h7F; hex_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_glitch();
    test_error();
    test_overrun();
    test_blank_repeat();
    test_reset_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
